// File: rtl/stack_pkg.sv
// Shared constants and operation encoding for the hardware stack and its processor.
package stack_pkg;
    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;
    localparam int STACK_PTR_W = $clog2(STACK_DEPTH) + 1;

    // Encoding matches {push, pop} so the request bits cast directly.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } stack_op_t;
endpackage

// File: rtl/stack_mem.sv
// Stack register array: one synchronous write port, one asynchronous read port.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // A register sampling o_rdata on the write edge sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/hw_stack.sv
// LIFO stack with registered pop data, saturating pointer and sticky error flags.
module hw_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [SPW-1:0]   r_sp;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf;
    logic             r_unf;

    stack_op_t        w_op;
    logic             w_full;
    logic             w_empty;
    logic [AW-1:0]    w_top;
    logic [SPW-1:0]   w_sp_nxt;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic             w_load;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [WIDTH-1:0] w_rdata;

    assign w_full  = (r_sp == SPW'(DEPTH));
    assign w_empty = (r_sp == '0);
    // Low bits wrap to DEPTH-1 when sp==DEPTH, which is the correct top.
    assign w_top   = r_sp[AW-1:0] - AW'(1);
    // Reset masks requests so no memory write happens while resetN is low.
    assign w_op    = resetN ? stack_op_t'({push, pop}) : OP_IDLE;

    always_comb begin
        w_sp_nxt  = r_sp;
        w_we      = 1'b0;
        w_waddr   = r_sp[AW-1:0];
        w_load    = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        unique case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we     = 1'b1;
                    w_sp_nxt = r_sp + SPW'(1);
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_load   = 1'b1;
                    w_sp_nxt = r_sp - SPW'(1);
                end
            end
            OP_BOTH: begin
                w_we = 1'b1;
                if (w_empty) begin
                    w_unf_set = 1'b1;
                    w_sp_nxt  = SPW'(1);
                end else begin
                    w_waddr = w_top;
                    w_load  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (data_in),
        .i_raddr (w_top),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_sp   <= '0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_sp <= w_sp_nxt;
            if (w_load) r_dout <= w_rdata;
            // A same-edge error wins over err_clr.
            r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
            r_unf <= w_unf_set | (r_unf & ~err_clr);
        end
    end

    assign data_out  = r_dout;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_sp;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
endmodule
